// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register. Redirect is combinational; everything the memory
// stage consumes comes straight out of flops.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] pc_address_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [3:0]      alu_op_i,
    input  logic [1:0]      alusrc_a_i,
    input  logic            alusrc_b_i,
    input  logic            branch_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic            regwrite_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic [1:0]      memtoreg_i,
    input  logic            fwd_mem_valid_i,
    input  logic            fwd_mem_regwrite_i,
    input  logic [4:0]      fwd_mem_rd_i,
    input  logic [XLEN-1:0] fwd_mem_data_i,
    input  logic            fwd_wb_valid_i,
    input  logic            fwd_wb_regwrite_i,
    input  logic [4:0]      fwd_wb_rd_i,
    input  logic [XLEN-1:0] fwd_wb_data_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            regwrite_o,
    output logic            memread_o,
    output logic            memwrite_o,
    output logic [4:0]      rd_addr_o,
    output logic [1:0]      memtoreg_o,
    output logic [XLEN-1:0] pc_address_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [2:0]      funct3_o,
    output logic            ex_valid_o
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Everything the memory stage sees, kept together so flush/stall/reset
    // treat every field identically.
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [4:0]      rd;
        logic [1:0]      memtoreg;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic [2:0]      funct3;
    } exmem_t;

    logic            mem_hit_rs1, wb_hit_rs1, mem_hit_rs2, wb_hit_rs2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] op_a, op_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_result;
    logic            br_cond;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            redirect;
    exmem_t          exmem_d, exmem_q;

    // A producer only counts when it really writes and targets a non-zero register.
    assign mem_hit_rs1 = fwd_mem_valid_i & fwd_mem_regwrite_i &
                         (fwd_mem_rd_i == rs1_addr_i) & (rs1_addr_i != 5'd0);
    assign wb_hit_rs1  = fwd_wb_valid_i & fwd_wb_regwrite_i &
                         (fwd_wb_rd_i == rs1_addr_i) & (rs1_addr_i != 5'd0);
    assign mem_hit_rs2 = fwd_mem_valid_i & fwd_mem_regwrite_i &
                         (fwd_mem_rd_i == rs2_addr_i) & (rs2_addr_i != 5'd0);
    assign wb_hit_rs2  = fwd_wb_valid_i & fwd_wb_regwrite_i &
                         (fwd_wb_rd_i == rs2_addr_i) & (rs2_addr_i != 5'd0);

    // Forwarding mux: the younger (memory-stage) producer overrides writeback.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fwd_rs1 = rs1_data_i;
        fwd_rs2 = rs2_data_i;
        if (wb_hit_rs1)  fwd_rs1 = fwd_wb_data_i;
        if (mem_hit_rs1) fwd_rs1 = fwd_mem_data_i;
        if (wb_hit_rs2)  fwd_rs2 = fwd_wb_data_i;
        if (mem_hit_rs2) fwd_rs2 = fwd_mem_data_i;
    end

    // Operand selection for the ALU.
    always_comb begin
        case (alusrc_a_i)
            2'b00:   op_a = fwd_rs1;
            2'b01:   op_a = pc_address_i;
            default: op_a = '0;
        endcase
        op_b  = alusrc_b_i ? imm_i : fwd_rs2;
        shamt = op_b[4:0];
    end

    // ALU; undefined op codes yield zero.
    always_comb begin
        case (alu_op_e'(alu_op_i))
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_result = op_a | op_b;
            ALU_AND:  alu_result = op_a & op_b;
            default:  alu_result = '0;
        endcase
    end

    // Branch condition on the forwarded register operands.
    always_comb begin
        case (funct3_i)
            3'b000:  br_cond = (fwd_rs1 == fwd_rs2);
            3'b001:  br_cond = (fwd_rs1 != fwd_rs2);
            3'b100:  br_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            3'b101:  br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            3'b110:  br_cond = (fwd_rs1 <  fwd_rs2);
            3'b111:  br_cond = (fwd_rs1 >= fwd_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    // Target: jalr is register-relative with bit 0 forced low, the rest PC-relative.
    assign jalr_sum      = fwd_rs1 + imm_i;
    assign target        = jalr_i ? (jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1})
                                  : (pc_address_i + imm_i);
    assign redirect      = id_valid_i & ~stall_i & ~flush_i &
                           (jal_i | jalr_i | (branch_i & br_cond));
    assign redirect_o    = redirect;
    assign redirect_pc_o = redirect ? target : '0;

    // Next EX/MEM contents; side-effecting controls are gated by valid so bubbles never write.
    always_comb begin
        exmem_d            = '0;
        exmem_d.valid      = id_valid_i;
        exmem_d.regwrite   = regwrite_i & id_valid_i;
        exmem_d.memread    = memread_i  & id_valid_i;
        exmem_d.memwrite   = memwrite_i & id_valid_i;
        exmem_d.rd         = rd_addr_i;
        exmem_d.memtoreg   = memtoreg_i;
        exmem_d.pc         = pc_address_i;
        exmem_d.alu_result = alu_result;
        exmem_d.store_data = fwd_rs2;
        exmem_d.funct3     = funct3_i;
    end

    // EX/MEM register: reset, then flush (beats stall), then stall hold, then load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            exmem_q <= '0;
        end else if (flush_i) begin
            exmem_q <= '0;
        end else if (!stall_i) begin
            exmem_q <= exmem_d;
        end
    end

    assign ex_valid_o   = exmem_q.valid;
    assign regwrite_o   = exmem_q.regwrite;
    assign memread_o    = exmem_q.memread;
    assign memwrite_o   = exmem_q.memwrite;
    assign rd_addr_o    = exmem_q.rd;
    assign memtoreg_o   = exmem_q.memtoreg;
    assign pc_address_o = exmem_q.pc;
    assign alu_result_o = exmem_q.alu_result;
    assign store_data_o = exmem_q.store_data;
    assign funct3_o     = exmem_q.funct3;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- RV32I execute stage, directly upstream of the memory stage.
- Consumes the ID/EX operands and control, applies operand forwarding, computes the ALU result and the branch/jump outcome.
- Drives a fetch redirect and registers everything the memory stage needs into the EX/MEM register.
- The memory stage uses alu_result_o, store_data_o, memread_o, memwrite_o, funct3_o and ex_valid_o directly as its BRAM request, so these outputs must be clean registered values.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold the EX/MEM register.
- flush_i  in  1  clear the EX/MEM register to a bubble.
- id_valid_i  in  1  the ID/EX slot holds a real instruction.
- pc_address_i  in  32  PC of the instruction.
- rs1_addr_i, rs2_addr_i  in  5 each  source register indices.
- rs1_data_i, rs2_data_i  in  32 each  register-file read data.
- imm_i  in  32  sign-extended immediate.
- rd_addr_i  in  5  destination register.
- alu_op_i  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; other codes produce 0.
- alusrc_a_i  in  2  00 rs1, 01 PC, 10 zero, 11 zero.
- alusrc_b_i  in  1  0 rs2, 1 imm.
- branch_i, jal_i, jalr_i  in  1 each  control-flow type.
- funct3_i  in  3  branch condition or load/store size.
- regwrite_i, memread_i, memwrite_i  in  1 each  writeback and memory control.
- memtoreg_i  in  2  00 ALU, 01 MEM, 10 PC+4.
- fwd_mem_valid_i, fwd_mem_regwrite_i  in  1 each  qualifiers for the older in-flight producer.
- fwd_mem_rd_i  in  5  destination of the older in-flight producer.
- fwd_mem_data_i  in  32  result of the older in-flight producer.
- fwd_wb_valid_i, fwd_wb_regwrite_i  in  1 each  qualifiers for the writeback producer.
- fwd_wb_rd_i  in  5  destination of the writeback producer.
- fwd_wb_data_i  in  32  result of the writeback producer.
- redirect_o  out  1  a taken branch or jump is in EX this cycle.
- redirect_pc_o  out  32  target address.
- regwrite_o, memread_o, memwrite_o  out  1 each  registered control.
- rd_addr_o  out  5  registered destination.
- memtoreg_o  out  2  registered writeback select.
- pc_address_o  out  32  registered PC (unchanged; PC+4 is formed downstream).
- alu_result_o  out  32  registered ALU result / byte address.
- store_data_o  out  32  registered forwarded rs2, unsteered.
- funct3_o  out  3  registered funct3.
- ex_valid_o  out  1  registered valid.

Behaviour:
- Forwarding is evaluated independently for rs1 and rs2:
  - Memory producer matches when fwd_mem_valid_i & fwd_mem_regwrite_i & rd == rsX & rsX != 0.
  - Writeback producer matches under the same rule using the fwd_wb_* ports.
  - If both match, the memory producer wins; if neither matches, use the register-file data.
  - x0 is never forwarded.
- ALU:
  - Operand A from alusrc_a_i; operand B from alusrc_b_i.
  - Shift amount is B[4:0]. SRA is arithmetic. SLT is signed, SLTU unsigned; both return 0 or 1.
  - All arithmetic wraps mod 2^32.
- Branch conditions on forwarded rs1/rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Codes 010 and 011 are never taken.
- Branch/jump targets:
  - Branch and jal: PC + imm.
  - jalr: (fwd_rs1 + imm) with bit 0 cleared.
- redirect_o = id_valid_i & ~stall_i & ~flush_i & (jal_i | jalr_i | (branch_i & cond)). It is combinational, same cycle.
- redirect_pc_o is the target; it is 0 when redirect_o = 0.
- EX/MEM register update priority (highest first):
  - rst_i asynchronously clears every registered output to 0.
  - flush_i clears every registered output to 0 on the clock edge, even when stall_i = 1.
  - stall_i holds all registered outputs.
  - Otherwise, on the clock edge:
    - ex_valid_o <= id_valid_i.
    - regwrite_o, memread_o and memwrite_o <= input AND id_valid_i, so a bubble never writes.
    - All other fields <= their inputs or computed values.
- Latency: one cycle from ID/EX inputs to EX/MEM outputs; redirect has zero latency.
- Reset mid-operation: outputs go to 0 immediately; the first edge after release loads normally.

Test Plan:
- ADD x3 with rs1 = 5, rs2 = 7, alusrc_b = 0, alu_op = 0 -> next cycle alu_result_o = 12, ex_valid_o = 1, regwrite_o = 1.
- rs1 = x4 with both fwd_mem (rd 4, data 0x11) and fwd_wb (rd 4, data 0x22) matching -> ADD with imm 0 yields 0x11. Repeat with rs1 = x0 and both producers matching -> yields 0.
- BEQ at PC 0x100, imm 0x20, forwarded operands equal -> redirect_o = 1 and redirect_pc_o = 0x120 that cycle. Repeat with operands unequal -> redirect_o = 0 and redirect_pc_o = 0.
- jalr with rs1 = 0x1003, imm 4 -> redirect_pc_o = 0x1006; registered pc_address_o equals the input PC.
- SRA with rs1 = 0x80000000 and shift amount 0x21 -> alu_result_o = 0xC0000000. Then SLTU with operands 0xFFFFFFFF and 1 -> 0.
- Store loaded while stall_i = 1 -> outputs hold; then flush_i and stall_i both 1 -> all outputs 0. Separately, id_valid_i = 0 with memwrite_i = 1 -> memwrite_o = 0.
